// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Stall/flush controller for a five-stage MIPS pipeline. It compares the
// operand-use time (Tuse) of the instruction in D against the remaining
// result-ready time (Tnew) of the producers in E and M. It also tracks the
// multiply/divide unit occupancy and applies exception flushes. All pipeline
// sequencing lives here, so the pipeline registers stay plain storage.
//
// Parameters
//   MULT_CYCLES   busy cycles for mult/multu
//   DIV_CYCLES    busy cycles for div/divu
//
// Ports
//   i_clk            system clock
//   i_reset          asynchronous active-high reset
//   i_rs_addr_D      rs source register of the D instruction
//   i_rt_addr_D      rt source register of the D instruction
//   i_rs_use_D       Tuse of rs in D (4 = operand unused)
//   i_rt_use_D       Tuse of rt in D (4 = operand unused)
//   i_dst_addr_E     destination register at the ID/EX output
//   i_dst_save_E     remaining Tnew at the ID/EX output
//   i_dst_addr_M     destination register at the EX/MEM output
//   i_dst_save_M     remaining Tnew at the EX/MEM output
//   i_md_use_D       D instruction touches HI/LO or starts the MDU
//   i_md_start_E     mult/div is in E this cycle
//   i_md_is_div_E    the starting MDU op is a divide
//   i_exc_req_M      exception/interrupt taken for the instruction in M
//   o_pc_en          PC register enable
//   o_ifid_en        IF/ID register enable
//   o_idex_en        ID/EX register enable
//   o_idex_clr       load ID/EX with a bubble
//   o_exmem_clr      load EX/MEM with a bubble
//   o_ifid_clr       load IF/ID with a bubble
//   o_md_busy        MDU occupied (registered)
//   o_stall          debug: data or MDU stall condition
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [4:0] i_rs_addr_D,
  input  logic [4:0] i_rt_addr_D,
  input  logic [3:0] i_rs_use_D,
  input  logic [3:0] i_rt_use_D,
  input  logic [4:0] i_dst_addr_E,
  input  logic [3:0] i_dst_save_E,
  input  logic [4:0] i_dst_addr_M,
  input  logic [3:0] i_dst_save_M,
  input  logic       i_md_use_D,
  input  logic       i_md_start_E,
  input  logic       i_md_is_div_E,
  input  logic       i_exc_req_M,
  output logic       o_pc_en,
  output logic       o_ifid_en,
  output logic       o_idex_en,
  output logic       o_idex_clr,
  output logic       o_exmem_clr,
  output logic       o_ifid_clr,
  output logic       o_md_busy,
  output logic       o_stall
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Data hazard detection, one instance per source port (0 = rs, 1 = rt)
  // ---------------------------------------------------------------------------
  logic [4:0] w_src_addr [2];
  logic [3:0] w_src_use  [2];
  logic [1:0] w_src_hazard;

  assign w_src_addr[0] = i_rs_addr_D;
  assign w_src_addr[1] = i_rt_addr_D;
  assign w_src_use[0]  = i_rs_use_D;
  assign w_src_use[1]  = i_rt_use_D;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic w_match_E;
      logic w_match_M;

      // A producer blocks only if its result is not ready by the time the
      // consumer needs it: Tuse < Tnew. $0 is never a real dependency.
      assign w_match_E = (w_src_addr[gi] == i_dst_addr_E) &&
                         (w_src_use[gi] < i_dst_save_E);
      assign w_match_M = (w_src_addr[gi] == i_dst_addr_M) &&
                         (w_src_use[gi] < i_dst_save_M);

      assign w_src_hazard[gi] = (w_src_addr[gi] != 5'd0) && (w_match_E || w_match_M);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // MDU occupancy FSM
  // ---------------------------------------------------------------------------
  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } md_state_t;

  md_state_t        r_state;
  md_state_t        w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        // A start paired with an exception belongs to a flushed, younger
        // instruction and must not occupy the MDU.
        if (i_md_start_E && !i_exc_req_M) begin
          w_state_next = S_BUSY;
          w_cnt_next   = i_md_is_div_E ? DIV_LOAD : MULT_LOAD;
        end
      end
      S_BUSY: begin
        // Starts are ignored here; exceptions do not abort the running
        // operation so HI/LO still completes. The count saturates at 0.
        if (r_cnt <= CNT_ONE) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt - CNT_ONE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  logic w_md_busy;
  assign w_md_busy = (r_state == S_BUSY);
  assign o_md_busy = w_md_busy;

  // ---------------------------------------------------------------------------
  // Stall / flush outputs
  // ---------------------------------------------------------------------------
  logic w_md_hazard;
  logic w_stall;

  // The start cycle itself also stalls: the busy flag only rises next cycle.
  assign w_md_hazard = i_md_use_D && (w_md_busy || i_md_start_E);
  assign w_stall     = (|w_src_hazard) || w_md_hazard;
  assign o_stall     = w_stall;

  always_comb begin
    o_pc_en     = 1'b1;
    o_ifid_en   = 1'b1;
    o_idex_en   = 1'b1;
    o_idex_clr  = 1'b0;
    o_exmem_clr = 1'b0;
    o_ifid_clr  = 1'b0;
    if (i_exc_req_M) begin
      // Flush everything younger than M; the PC keeps loading so the
      // handler address is taken even if a stall is pending.
      o_ifid_clr  = 1'b1;
      o_idex_clr  = 1'b1;
      o_exmem_clr = 1'b1;
    end else if (w_stall) begin
      // Hold PC and D, inject a bubble into E; E/M/W keep draining.
      o_pc_en    = 1'b0;
      o_ifid_en  = 1'b0;
      o_idex_clr = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic       clk;
  logic       rst;
  logic [4:0] rs_addr, rt_addr, dE_addr, dM_addr;
  logic [3:0] rs_use, rt_use, dE_save, dM_save;
  logic       md_use, md_start, md_div, exc;
  logic       pc_en, ifid_en, idex_en, idex_clr, exmem_clr, ifid_clr, md_busy, stall;

  pipe_hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_rs_addr_D  (rs_addr),
    .i_rt_addr_D  (rt_addr),
    .i_rs_use_D   (rs_use),
    .i_rt_use_D   (rt_use),
    .i_dst_addr_E (dE_addr),
    .i_dst_save_E (dE_save),
    .i_dst_addr_M (dM_addr),
    .i_dst_save_M (dM_save),
    .i_md_use_D   (md_use),
    .i_md_start_E (md_start),
    .i_md_is_div_E(md_div),
    .i_exc_req_M  (exc),
    .o_pc_en      (pc_en),
    .o_ifid_en    (ifid_en),
    .o_idex_en    (idex_en),
    .o_idex_clr   (idex_clr),
    .o_exmem_clr  (exmem_clr),
    .o_ifid_clr   (ifid_clr),
    .o_md_busy    (md_busy),
    .o_stall      (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the MDU is occupied for cycle numbers below busy_end.
  int cyc      = 0;
  int busy_end = 0;
  logic obs_stall, obs_busy;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  function automatic bit src_hazard(input logic [4:0] a, input logic [3:0] u);
    if (a == 5'd0) return 1'b0;
    return ((a == dE_addr) && (u < dE_save)) || ((a == dM_addr) && (u < dM_save));
  endfunction

  task automatic idle_inputs();
    rs_addr = 0; rt_addr = 0; rs_use = 4; rt_use = 4;
    dE_addr = 0; dE_save = 0; dM_addr = 0; dM_save = 0;
    md_use = 0; md_start = 0; md_div = 0; exc = 0;
  endtask

  // Called just after a negedge with inputs already driven: checks all
  // outputs against the model, then advances one clock.
  task automatic cycle(input string tag);
    bit e_busy, e_stall, e_pc, e_ifid_en, e_idex_clr, e_exmem_clr, e_ifid_clr;
    #1;
    if (rst) busy_end = 0;
    e_busy  = (cyc < busy_end);
    e_stall = src_hazard(rs_addr, rs_use) || src_hazard(rt_addr, rt_use) ||
              (md_use && (e_busy || md_start));
    e_pc = 1; e_ifid_en = 1; e_idex_clr = 0; e_exmem_clr = 0; e_ifid_clr = 0;
    if (exc) begin
      e_idex_clr = 1; e_exmem_clr = 1; e_ifid_clr = 1;
    end else if (e_stall) begin
      e_pc = 0; e_ifid_en = 0; e_idex_clr = 1;
    end
    chk({tag, ".md_busy"},   md_busy,   e_busy);
    chk({tag, ".stall"},     stall,     e_stall);
    chk({tag, ".pc_en"},     pc_en,     e_pc);
    chk({tag, ".ifid_en"},   ifid_en,   e_ifid_en);
    chk({tag, ".idex_en"},   idex_en,   1'b1);
    chk({tag, ".idex_clr"},  idex_clr,  e_idex_clr);
    chk({tag, ".exmem_clr"}, exmem_clr, e_exmem_clr);
    chk({tag, ".ifid_clr"},  ifid_clr,  e_ifid_clr);
    $display("cyc %0d %s: rs=%0d/%0d rt=%0d/%0d E=%0d/%0d M=%0d/%0d mdu=%b%b%b exc=%b rst=%b -> stall=%b busy=%b pc=%b",
             cyc, tag, rs_addr, rs_use, rt_addr, rt_use, dE_addr, dE_save, dM_addr, dM_save,
             md_use, md_start, md_div, exc, rst, stall, md_busy, pc_en);
    obs_stall = stall;
    obs_busy  = md_busy;
    @(posedge clk);
    if (!rst && !(cyc < busy_end) && md_start && !exc)
      busy_end = cyc + 1 + (md_div ? DIV_N : MULT_N);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    int n;
    int nbusy;
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);

    // Reset state, with a hazard present on the inputs
    rs_addr = 1; rs_use = 1; dE_addr = 1; dE_save = 2;
    cycle("reset");
    chk("reset.busy_low", md_busy, 1'b0);
    rst = 1'b0;
    idle_inputs();
    cycle("idle");

    // lw in E, addu reads it in D: one bubble, then the lw in M is ready
    rs_addr = 1; rs_use = 1; dE_addr = 1; dE_save = 2;
    cycle("lw_use_E");
    chk("lw_use_E.stall_seen", obs_stall, 1'b1);
    dE_addr = 0; dE_save = 0; dM_addr = 1; dM_save = 1;
    cycle("lw_use_M");
    chk("lw_use_M.stall_gone", obs_stall, 1'b0);

    // rt port hazard through M
    idle_inputs();
    rt_addr = 7; rt_use = 0; dM_addr = 7; dM_save = 1;
    cycle("rt_hazard_M");

    // $0 never hazards
    idle_inputs();
    dE_addr = 0; dE_save = 3; rs_addr = 0; rs_use = 0;
    cycle("reg0");
    chk("reg0.no_stall", obs_stall, 1'b0);

    // mult then mflo in D: stalls start cycle plus 5 busy cycles
    idle_inputs();
    md_use = 1; md_start = 1; md_div = 0;
    n = 0; nbusy = 0;
    for (int k = 0; k < 20; k++) begin
      cycle("mflo_wait");
      md_start = 0;
      if (obs_busy) nbusy++;
      if (!obs_stall) break;
      n++;
    end
    chk("mflo.stall_cycles", n, 6);
    chk("mult.busy_cycles", nbusy, MULT_N);

    // div with an exception at busy cycle 4: flush that cycle, busy stays 10
    idle_inputs();
    md_start = 1; md_div = 1;
    cycle("div_start");
    idle_inputs();
    nbusy = 0;
    for (int k = 1; k <= 12; k++) begin
      exc = (k == 4);
      cycle(k == 4 ? "div_exc" : "div_run");
      if (obs_busy) nbusy++;
    end
    chk("div.busy_cycles", nbusy, DIV_N);

    // start dropped when paired with an exception
    idle_inputs();
    md_start = 1; md_div = 1; exc = 1;
    cycle("start_exc");
    idle_inputs();
    cycle("start_exc_after");
    chk("start_exc.busy_low", obs_busy, 1'b0);

    // data hazard + exception: exception wins
    rs_addr = 3; rs_use = 0; dE_addr = 3; dE_save = 3; exc = 1;
    cycle("hazard_exc");
    chk("hazard_exc.pc_en", pc_en, 1'b1);

    // reset asserted during busy cycle 3
    idle_inputs();
    md_start = 1; md_div = 1;
    cycle("div_start2");
    idle_inputs();
    md_use = 1;
    for (int k = 1; k <= 2; k++) cycle("div_run2");
    #2 rst = 1'b1;
    #1 chk("async_reset.busy", md_busy, 1'b0);
    chk("async_reset.stall", stall, 1'b0);
    busy_end = 0;
    #1 rst = 1'b0;
    @(negedge clk);
    cycle("post_reset");
    cycle("post_reset2");

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      rs_addr = 5'($urandom_range(0, 3));
      rt_addr = 5'($urandom_range(0, 3));
      rs_use  = 4'($urandom_range(0, 4));
      rt_use  = 4'($urandom_range(0, 4));
      dE_addr = 5'($urandom_range(0, 3));
      dM_addr = 5'($urandom_range(0, 3));
      dE_save = 4'($urandom_range(0, 3));
      dM_save = 4'($urandom_range(0, 2));
      md_use  = 1'($urandom_range(0, 1));
      md_start = ($urandom_range(0, 7) == 0);
      md_div  = 1'($urandom_range(0, 1));
      exc     = ($urandom_range(0, 9) == 0);
      rst     = ($urandom_range(0, 63) == 0);
      cycle("rand");
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
